// File: rtl/color_palette.sv
// Tile-code to RGB palette with runtime-writable entries, per-pixel blink
// and global brightness dim. Fixed two-cycle latency, one pixel per cycle.
module color_palette #(
   parameter int unsigned CODE_W      = 3,
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned COLOR_W     = 8,
   parameter int unsigned BLINK_W     = 24
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_valid_in,
   input  logic [CODE_W-1:0]  data,
   input  logic               blink_in,
   input  logic [1:0]         dim_shift,
   input  logic               wr_en,
   input  logic [CODE_W-1:0]  wr_addr,
   input  logic [COLOR_W-1:0] wr_r,
   input  logic [COLOR_W-1:0] wr_g,
   input  logic [COLOR_W-1:0] wr_b,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b,
   output logic               pix_valid_out,
   output logic               blink_phase
);

   localparam int unsigned DEPTH   = 1 << CODE_W;
   localparam int unsigned ENTRY_W = 3 * COLOR_W;

   typedef logic [ENTRY_W-1:0] entry_t;

   // Standard tile colours loaded at reset; unused entries stay black.
   function automatic entry_t default_entry(input int unsigned idx);
      logic [COLOR_W-1:0] fs;
      logic [COLOR_W-1:0] z;
      entry_t             e;
      fs = '1;
      z  = '0;
      e  = '0;
      if (idx < NUM_ENTRIES) begin
         case (idx)
            1:       e = {fs, z,  z };
            2:       e = {z,  fs, z };
            3:       e = {z,  z,  fs};
            4:       e = {fs, fs, z };
            default: e = '0;
         endcase
      end
      return e;
   endfunction

   function automatic logic in_range(input logic [CODE_W-1:0] a);
      return 32'(a) < NUM_ENTRIES;
   endfunction

   entry_t               pal_q [DEPTH];
   entry_t               pal_d [DEPTH];
   logic [BLINK_W-1:0]   cnt_q, cnt_d;

   logic                 v1_q;
   logic [CODE_W-1:0]    code1_q;
   logic                 blink1_q;
   logic [1:0]           dim1_q;

   logic [COLOR_W-1:0]   r_q, g_q, b_q, r_d, g_d, b_d;
   logic                 vo_q, vo_d;
   entry_t               ent;

   // Palette write path; out-of-range addresses are dropped.
   always_comb begin
      pal_d = pal_q;
      if (wr_en && in_range(wr_addr)) begin
         pal_d[wr_addr] = {wr_r, wr_g, wr_b};
      end
   end

   // Palette storage, reloaded with defaults on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pal_q[i] <= default_entry(i);
         end
      end else begin
         pal_q <= pal_d;
      end
   end

   // Free-running blink counter, wraps naturally.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
   end

   // S2 lookup reads pal_q (pre-edge contents), so a same-edge write is seen
   // only by the following pixel. Invalid beats out-of-range beats blink.
   always_comb begin
      r_d  = '0;
      g_d  = '0;
      b_d  = '0;
      vo_d = 1'b0;
      ent  = pal_q[code1_q];
      if (v1_q) begin
         vo_d = 1'b1;
         if (in_range(code1_q) && !(blink1_q && cnt_q[BLINK_W-1])) begin
            r_d = ent[3*COLOR_W-1 -: COLOR_W] >> dim1_q;
            g_d = ent[2*COLOR_W-1 -: COLOR_W] >> dim1_q;
            b_d = ent[COLOR_W-1   -: COLOR_W] >> dim1_q;
         end
      end
   end

   // Blink counter plus S1 and S2 pipeline registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         v1_q     <= 1'b0;
         code1_q  <= '0;
         blink1_q <= 1'b0;
         dim1_q   <= '0;
         r_q      <= '0;
         g_q      <= '0;
         b_q      <= '0;
         vo_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         v1_q     <= pix_valid_in;
         code1_q  <= data;
         blink1_q <= blink_in;
         dim1_q   <= dim_shift;
         r_q      <= r_d;
         g_q      <= g_d;
         b_q      <= b_d;
         vo_q     <= vo_d;
      end
   end

   assign r             = r_q;
   assign g             = g_q;
   assign b             = b_q;
   assign pix_valid_out = vo_q;
   assign blink_phase   = cnt_q[BLINK_W-1];

endmodule
